snn_layer_tm: RTL and testbench
===============================

Name: snn_layer_tm

Overview:
Time-multiplexed leaky-integrate-and-fire (LIF) layer, the parametrised successor of the fully parallel layer.
- Synapses are serialised through one MAC, one synapse per cycle.
- Weights live in an internal register file loaded through a write port.
- Neurons gain leak, refractory period, saturation and clear-state.
- Spike vectors are exchanged per timestep over valid/ready handshakes, so layers chain into a pipeline.

Parameters:
N_NEURONS, 4, neurons in this layer
PREV_NEURONS, 4, presynaptic inputs
W, 8, signed weight width
V_WIDTH, 16, signed membrane width
THRESHOLD, 64, fire when v_new >= THRESHOLD (signed, fits V_WIDTH)
LEAK_SHIFT, 3, leak = v >>> LEAK_SHIFT (arithmetic)
REFRAC_STEPS, 2, timesteps a neuron ignores input after firing

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  spike vector valid
in_ready  out  1  layer can accept a timestep
spikes_in  in  PREV_NEURONS  presynaptic spikes
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
spikes_out  out  N_NEURONS  postsynaptic spikes
w_we  in  1  weight write strobe
w_ready  out  1  weight write accepted this cycle
w_addr_n  in  clog2(N_NEURONS)  target neuron
w_addr_p  in  clog2(PREV_NEURONS)  target input
w_data  in  W  signed weight
clear_state  in  1  zero membranes and refractory counters

Behaviour:
- Reset (async assert, sync release) clears:
  - FSM to IDLE; in_ready=1, out_valid=0, spikes_out=0, w_ready=1.
  - All weights, membranes, refractory counters and the accumulator to 0.
- FSM is IDLE -> ACCUM -> UPDATE -> (ACCUM next neuron | DONE) -> IDLE.
- IDLE:
  - in_ready=w_ready=1.
  - Priority: clear_state > w_we > in_valid.
  - clear_state zeroes v[] and refrac[] and takes one cycle; in_valid is not accepted that cycle.
  - w_we writes weights[w_addr_n][w_addr_p]. A simultaneous in_valid is not accepted; the source holds it.
  - in_valid&&in_ready latches spikes_in, sets n=0, p=0, acc=0, goes to ACCUM.
- ACCUM:
  - One synapse per cycle: acc += spk[p] ? weights[n][p] : 0.
  - acc width is W+clog2(PREV_NEURONS)+1, so it never overflows.
  - Exactly PREV_NEURONS cycles, then UPDATE. No zero-skip; latency is fixed.
- UPDATE (one cycle per neuron):
  - If refrac[n]>0: refrac[n]--, v[n]=0, spike bit 0, acc discarded.
  - Else v_new = sat(v - (v>>>LEAK_SHIFT) + acc), saturating to the signed V_WIDTH range.
  - If v_new >= THRESHOLD: spike bit 1, v[n]=0, refrac[n]=REFRAC_STEPS. Otherwise v[n]=v_new.
  - n++ then ACCUM with acc=0, or DONE after the last neuron.
- DONE:
  - out_valid=1; spikes_out is held stable until out_ready; in_ready=w_ready=0.
  - On handshake: out_valid=0 and return to IDLE next cycle.
- Latency: input accepted at edge T gives out_valid high from T+1+N_NEURONS*(PREV_NEURONS+1). Default: T+21.
- Outside IDLE, w_we and clear_state are ignored (w_ready=0).
- A reset during ACCUM/UPDATE/DONE drops the in-flight timestep; no partial spikes_out is emitted.

Decomposition:
- snn_pkg holds:
  - the state enum (IDLE, ACCUM, UPDATE, DONE)
  - sat_add function (signed saturating add, width-generic via parameterised class or fixed max)
  - default THRESHOLD/LEAK constants
- One sub-module, lif_update: combinational leak+add+saturate+threshold+refractory decision for one neuron, instantiated once and shared.

Test Plan:
- Fire: weights[0][*]=32, spikes_in=4'b1111 accepted at T -> out_valid at T+21, spikes_out=4'b0001, v[0]=0.
- Leak: weights[1][0]=40, others 0; steps spikes_in=0001,0000,0000 -> v[1]=40,35,31; no spikes; also v=-40 with zero input -> -35.
- Refractory: neuron 0 fires at step k with the fire stimulus repeated at k+1, k+2, k+3 -> spikes_out bit0 = 0 at k+1 and k+2 with v[0]=0, then 1 at k+3.
- Saturation (V_WIDTH=8): weights[2][*]=127, all spikes -> acc=508, v_new saturates to 127 >= 64, bit2 fires; with weights=-128 -> v=-128, no fire, no wrap.
- Backpressure/priority: hold out_ready=0 for 10 cycles in DONE -> out_valid and spikes_out stable, in_ready=w_ready=0, w_we ignored (readback shows old weight); in IDLE, w_we and in_valid together -> write taken, in_valid accepted next cycle.
- Reset mid-ACCUM: rst_n low at T+7 -> out_valid=0 and in_ready=1 immediately, weights/membranes 0, next timestep output 0000; clear_state in IDLE after fire-less steps -> v[] all 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the time-multiplexed LIF layer.
package snn_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StUpdate, StDone} state_e;

  localparam int          DefThreshold = 64;
  localparam int unsigned DefLeakShift = 3;

  // Signed add of two 32-bit operands, clamped to the signed range of 'width' bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        width);
    logic signed [32:0] sum;
    logic signed [32:0] vmax;
    logic signed [32:0] vmin;
    sum  = {a[31], a} + {b[31], b};
    vmax = (33'sd1 <<< (width - 1)) - 33'sd1;
    vmin = -(33'sd1 <<< (width - 1));
    if (sum > vmax) begin
      sat_add = vmax[31:0];
    end else if (sum < vmin) begin
      sat_add = vmin[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leak, integrate, saturate, threshold and refractory decision for one neuron.
module lif_update import snn_pkg::*; #(
  parameter int unsigned V_WIDTH      = 16,
  parameter int unsigned A_WIDTH      = 11,
  parameter int          THRESHOLD    = DefThreshold,
  parameter int unsigned LEAK_SHIFT   = DefLeakShift,
  parameter int unsigned REFRAC_STEPS = 2,
  parameter int unsigned R_WIDTH      = 2
) (
  input  logic signed [V_WIDTH-1:0] v_i,
  input  logic signed [A_WIDTH-1:0] acc_i,
  input  logic        [R_WIDTH-1:0] refrac_i,
  output logic signed [V_WIDTH-1:0] v_o,
  output logic        [R_WIDTH-1:0] refrac_o,
  output logic                      spike_o
);

  logic signed [31:0] v_ext;
  logic signed [31:0] acc_ext;
  logic signed [31:0] leaked;
  logic signed [31:0] v_new;

  assign v_ext   = {{(32 - V_WIDTH){v_i[V_WIDTH-1]}}, v_i};
  assign acc_ext = {{(32 - A_WIDTH){acc_i[A_WIDTH-1]}}, acc_i};
  assign leaked  = v_ext - (v_ext >>> LEAK_SHIFT);
  assign v_new   = sat_add(leaked, acc_ext, V_WIDTH);

  always_comb begin
    v_o      = v_i;
    refrac_o = refrac_i;
    spike_o  = 1'b0;
    if (refrac_i != '0) begin
      // Refractory: input is discarded and the membrane held at rest.
      refrac_o = refrac_i - R_WIDTH'(1);
      v_o      = '0;
    end else if (v_new >= THRESHOLD) begin
      spike_o  = 1'b1;
      v_o      = '0;
      refrac_o = R_WIDTH'(REFRAC_STEPS);
    end else begin
      v_o = v_new[V_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/snn_layer_tm.sv
// Time-multiplexed LIF layer: one synapse per cycle through a single MAC, per-timestep handshakes.
module snn_layer_tm import snn_pkg::*; #(
  parameter int unsigned N_NEURONS    = 4,
  parameter int unsigned PREV_NEURONS = 4,
  parameter int unsigned W            = 8,
  parameter int unsigned V_WIDTH      = 16,
  parameter int          THRESHOLD    = DefThreshold,
  parameter int unsigned LEAK_SHIFT   = DefLeakShift,
  parameter int unsigned REFRAC_STEPS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PREV_NEURONS-1:0]         spikes_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_NEURONS-1:0]            spikes_out,
  input  logic                            w_we,
  output logic                            w_ready,
  input  logic [$clog2(N_NEURONS)-1:0]    w_addr_n,
  input  logic [$clog2(PREV_NEURONS)-1:0] w_addr_p,
  input  logic signed [W-1:0]             w_data,
  input  logic                            clear_state
);

  localparam int unsigned NW = $clog2(N_NEURONS);
  localparam int unsigned PW = $clog2(PREV_NEURONS);
  localparam int unsigned AW = W + PW + 1;
  localparam int unsigned RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic [NW-1:0] NLast = NW'(N_NEURONS - 1);
  localparam logic [PW-1:0] PLast = PW'(PREV_NEURONS - 1);

  state_e                   state_q, state_d;
  logic [NW-1:0]            n_q, n_d;
  logic [PW-1:0]            p_q, p_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [PREV_NEURONS-1:0]  spk_q, spk_d;
  logic [N_NEURONS-1:0]     out_spk_q, out_spk_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [W-1:0]       weights_q [N_NEURONS][PREV_NEURONS];
  logic signed [V_WIDTH-1:0] v_q       [N_NEURONS];
  logic [RW-1:0]             refrac_q  [N_NEURONS];

  logic                      idle;
  logic                      clr_fire;
  logic                      w_fire;
  logic signed [W-1:0]       w_sel;
  logic signed [AW-1:0]      addend;
  logic signed [V_WIDTH-1:0] lif_v;
  logic [RW-1:0]             lif_refrac;
  logic                      lif_spike;

  assign idle     = (state_q == StIdle);
  assign clr_fire = idle && clear_state;
  assign w_fire   = idle && !clear_state && w_we;

  // in_ready drops while a clear or weight write owns the IDLE cycle, so the source holds.
  assign in_ready   = idle && !clear_state && !w_we;
  assign w_ready    = idle && !clear_state;
  assign out_valid  = out_valid_q;
  assign spikes_out = out_spk_q;

  assign w_sel  = weights_q[n_q][p_q];
  assign addend = spk_q[p_q] ? {{(AW - W){w_sel[W-1]}}, w_sel} : '0;

  lif_update #(
    .V_WIDTH     (V_WIDTH),
    .A_WIDTH     (AW),
    .THRESHOLD   (THRESHOLD),
    .LEAK_SHIFT  (LEAK_SHIFT),
    .REFRAC_STEPS(REFRAC_STEPS),
    .R_WIDTH     (RW)
  ) u_lif (
    .v_i     (v_q[n_q]),
    .acc_i   (acc_q),
    .refrac_i(refrac_q[n_q]),
    .v_o     (lif_v),
    .refrac_o(lif_refrac),
    .spike_o (lif_spike)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    p_d         = p_q;
    acc_d       = acc_q;
    spk_d       = spk_q;
    out_spk_d   = out_spk_q;
    out_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_ready && in_valid) begin
          spk_d     = spikes_in;
          n_d       = '0;
          p_d       = '0;
          acc_d     = '0;
          out_spk_d = '0;
          state_d   = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_q + addend;
        if (p_q == PLast) begin
          p_d     = '0;
          state_d = StUpdate;
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      StUpdate: begin
        out_spk_d[n_q] = lif_spike;
        acc_d          = '0;
        if (n_q == NLast) begin
          state_d = StDone;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = StAccum;
        end
      end
      StDone: begin
        if (out_valid_q && out_ready) begin
          state_d = StIdle;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      p_q         <= '0;
      acc_q       <= '0;
      spk_q       <= '0;
      out_spk_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      spk_q       <= spk_d;
      out_spk_q   <= out_spk_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        for (int j = 0; j < int'(PREV_NEURONS); j++) begin
          weights_q[i][j] <= '0;
        end
      end
    end else if (w_fire) begin
      weights_q[w_addr_n][w_addr_p] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        v_q[i]      <= '0;
        refrac_q[i] <= '0;
      end
    end else if (clr_fire) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        v_q[i]      <= '0;
        refrac_q[i] <= '0;
      end
    end else if (state_q == StUpdate) begin
      v_q[n_q]      <= lif_v;
      refrac_q[n_q] <= lif_refrac;
    end
  end

endmodule

// File: tb/tb_snn_layer_tm.sv
// Self-checking bench for snn_layer_tm against a timestep-level LIF reference model.
module tb_snn_layer_tm;

  localparam int N   = 4;
  localparam int P   = 4;
  localparam int VW  = 8;
  localparam int TH  = 64;
  localparam int LS  = 3;
  localparam int RS  = 2;
  localparam int LAT = N * (P + 1) + 1;
  localparam int VMAX = (1 << (VW - 1)) - 1;
  localparam int VMIN = -(1 << (VW - 1));

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [P-1:0]      spikes_in;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      spikes_out;
  logic              w_we;
  logic              w_ready;
  logic [1:0]        w_addr_n;
  logic [1:0]        w_addr_p;
  logic signed [7:0] w_data;
  logic              clear_state;

  int checks = 0;
  int errors = 0;

  int m_w [N][P];
  int m_v [N];
  int m_r [N];

  always #5 clk = ~clk;

  snn_layer_tm #(
    .N_NEURONS   (N),
    .PREV_NEURONS(P),
    .W           (8),
    .V_WIDTH     (VW),
    .THRESHOLD   (TH),
    .LEAK_SHIFT  (LS),
    .REFRAC_STEPS(RS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .spikes_in  (spikes_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .spikes_out (spikes_out),
    .w_we       (w_we),
    .w_ready    (w_ready),
    .w_addr_n   (w_addr_n),
    .w_addr_p   (w_addr_p),
    .w_data     (w_data),
    .clear_state(clear_state)
  );

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      m_v[n] = 0;
      m_r[n] = 0;
      for (int p = 0; p < P; p++) m_w[n][p] = 0;
    end
  endtask

  task automatic model_step(input logic [P-1:0] spk, output logic [N-1:0] exp_s);
    int acc;
    int vn;
    exp_s = '0;
    for (int n = 0; n < N; n++) begin
      acc = 0;
      for (int p = 0; p < P; p++) if (spk[p]) acc += m_w[n][p];
      if (m_r[n] > 0) begin
        m_r[n] -= 1;
        m_v[n] = 0;
      end else begin
        vn = m_v[n] - (m_v[n] >>> LS) + acc;
        if (vn > VMAX) vn = VMAX;
        if (vn < VMIN) vn = VMIN;
        if (vn >= TH) begin
          exp_s[n] = 1'b1;
          m_v[n]   = 0;
          m_r[n]   = RS;
        end else begin
          m_v[n] = vn;
        end
      end
    end
  endtask

  task automatic write_w(input int n, input int p, input int d);
    w_we     = 1'b1;
    w_addr_n = 2'(n);
    w_addr_p = 2'(p);
    w_data   = 8'(d);
    @(posedge clk);
    #1;
    w_we     = 1'b0;
    m_w[n][p] = d;
  endtask

  task automatic pulse_clear();
    clear_state = 1'b1;
    @(posedge clk);
    #1;
    clear_state = 1'b0;
    for (int n = 0; n < N; n++) begin
      m_v[n] = 0;
      m_r[n] = 0;
    end
  endtask

  // Drives one timestep through the DUT; lat counts edges after the accept edge (-1 on timeout).
  task automatic run_step(input logic [P-1:0] spk, output logic [N-1:0] got, output int lat);
    int guard;
    in_valid  = 1'b1;
    spikes_in = spk;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    spikes_in = '0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    got = spikes_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (spikes_out !== '0) begin errors++; $display("FAIL reset_spikes: got %b want 0000", spikes_out); end
    if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_w_ready: got %b want 1", w_ready); end
  endtask

  task automatic test_fire();
    logic [N-1:0] got, exp_s;
    int lat;
    for (int p = 0; p < P; p++) write_w(0, p, 32);
    model_step(4'b1111, exp_s);
    run_step(4'b1111, got, lat);
    checks += 3;
    if (lat !== LAT) begin errors++; $display("FAIL fire_latency: got %0d want %0d", lat, LAT); end
    if (got !== exp_s) begin errors++; $display("FAIL fire_model: got %b want %b", got, exp_s); end
    if (got !== 4'b0001) begin errors++; $display("FAIL fire_spikes: got %b want 0001", got); end
  endtask

  task automatic test_refractory();
    logic [N-1:0] got, exp_s;
    int lat;
    for (int k = 1; k <= 3; k++) begin
      model_step(4'b1111, exp_s);
      run_step(4'b1111, got, lat);
      checks += 2;
      if (got !== exp_s) begin
        errors++; $display("FAIL refrac_step%0d: got %b want %b", k, got, exp_s);
      end
      if (got[0] !== (k == 3)) begin
        errors++; $display("FAIL refrac_bit0_step%0d: got %b want %b", k, got[0], (k == 3));
      end
    end
  endtask

  task automatic test_leak();
    logic [N-1:0] got, exp_s;
    logic [P-1:0] seq [4];
    int lat;
    seq[0] = 4'b0001; seq[1] = 4'b0000; seq[2] = 4'b0000; seq[3] = 4'b0010;
    pulse_clear();
    write_w(1, 0, 40);
    for (int i = 0; i < 4; i++) begin
      // Last step lands neuron 1 exactly on threshold only if leak is 31 -> 28.
      if (i == 3) write_w(1, 1, 36);
      model_step(seq[i], exp_s);
      run_step(seq[i], got, lat);
      checks += 1;
      if (got !== exp_s) begin errors++; $display("FAIL leak_step%0d: got %b want %b", i, got, exp_s); end
    end
    checks += 1;
    if (got[1] !== 1'b1) begin errors++; $display("FAIL leak_thresh_eq: got %b want 1", got[1]); end
  endtask

  task automatic test_saturation();
    logic [N-1:0] got, exp_s;
    logic [P-1:0] seq [7];
    int lat;
    seq[0] = 4'b1111; seq[1] = 4'b0000; seq[2] = 4'b0000; seq[3] = 4'b1111;
    seq[4] = 4'b1111; seq[5] = 4'b1111; seq[6] = 4'b1111;
    pulse_clear();
    for (int p = 0; p < P; p++) write_w(2, p, 127);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) for (int p = 0; p < P; p++) write_w(2, p, -128);
      if (i == 5) for (int p = 0; p < P; p++) write_w(2, p, 20);
      model_step(seq[i], exp_s);
      run_step(seq[i], got, lat);
      checks += 1;
      if (got !== exp_s) begin errors++; $display("FAIL sat_step%0d: got %b want %b", i, got, exp_s); end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] got, exp_s;
    int lat;
    int guard;
    pulse_clear();
    model_step(4'b0001, exp_s);
    in_valid = 1'b1; spikes_in = 4'b0001;
    @(posedge clk); #1;
    in_valid = 1'b0; spikes_in = '0;
    guard = 0;
    while (!out_valid && guard < 200) begin @(posedge clk); #1; guard++; end
    for (int c = 0; c < 10; c++) begin
      w_we = 1'b1; w_addr_n = 2'd3; w_addr_p = 2'd0; w_data = 8'sd100;
      #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b want 1", c, out_valid); end
      if (spikes_out !== exp_s) begin
        errors++; $display("FAIL bp_spikes_c%0d: got %b want %b", c, spikes_out, exp_s);
      end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); end
      if (w_ready !== 1'b0) begin errors++; $display("FAIL bp_w_ready_c%0d: got %b want 0", c, w_ready); end
      @(posedge clk); #1;
    end
    w_we = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks += 1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid: got %b want 0", out_valid); end
    // Weight 3,0 must still be 0: a write landing in DONE would make neuron 3 fire here.
    model_step(4'b0001, exp_s);
    run_step(4'b0001, got, lat);
    checks += 2;
    if (got !== exp_s) begin errors++; $display("FAIL bp_ignored_write: got %b want %b", got, exp_s); end
    if (got[3] !== 1'b0) begin errors++; $display("FAIL bp_n3_quiet: got %b want 0", got[3]); end

    // Simultaneous write and input in IDLE: write first, input accepted next cycle.
    w_we = 1'b1; w_addr_n = 2'd3; w_addr_p = 2'd1; w_data = 8'sd70;
    in_valid = 1'b1; spikes_in = 4'b0010;
    #1;
    checks += 2;
    if (w_ready !== 1'b1) begin errors++; $display("FAIL prio_w_ready: got %b want 1", w_ready); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL prio_in_blocked: got %b want 0", in_ready); end
    @(posedge clk); #1;
    w_we = 1'b0;
    m_w[3][1] = 70;
    #1;
    checks += 1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_in_ready: got %b want 1", in_ready); end
    model_step(4'b0010, exp_s);
    run_step(4'b0010, got, lat);
    checks += 3;
    if (lat !== LAT) begin errors++; $display("FAIL prio_latency: got %0d want %0d", lat, LAT); end
    if (got !== exp_s) begin errors++; $display("FAIL prio_spikes: got %b want %b", got, exp_s); end
    if (got[3] !== 1'b1) begin errors++; $display("FAIL prio_n3_fire: got %b want 1", got[3]); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] got, exp_s;
    int lat;
    in_valid = 1'b1; spikes_in = 4'b1111;
    @(posedge clk); #1;
    in_valid = 1'b0; spikes_in = '0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    model_step(4'b1111, exp_s);
    run_step(4'b1111, got, lat);
    checks += 3;
    if (lat !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
    if (got !== exp_s) begin errors++; $display("FAIL midrst_model: got %b want %b", got, exp_s); end
    if (got !== 4'b0000) begin errors++; $display("FAIL midrst_spikes: got %b want 0000", got); end
  endtask

  task automatic test_clear();
    logic [N-1:0] got, exp_s;
    int lat;
    write_w(0, 0, 40);
    model_step(4'b0001, exp_s); run_step(4'b0001, got, lat);
    model_step(4'b0000, exp_s); run_step(4'b0000, got, lat);
    pulse_clear();
    // Without the clear, v[0]=35 would leak to 31 and fire with +40.
    model_step(4'b0001, exp_s);
    run_step(4'b0001, got, lat);
    checks += 2;
    if (got !== exp_s) begin errors++; $display("FAIL clear_model: got %b want %b", got, exp_s); end
    if (got[0] !== 1'b0) begin errors++; $display("FAIL clear_n0: got %b want 0", got[0]); end
  endtask

  task automatic test_random();
    logic [N-1:0]      got, exp_s;
    logic [P-1:0]      spk;
    logic signed [7:0] rw;
    int lat;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 3; k++) begin
          rw = 8'($urandom);
          write_w(int'($urandom_range(0, N - 1)), int'($urandom_range(0, P - 1)), int'(rw));
        end
      end
      if ($urandom_range(0, 9) == 0) pulse_clear();
      spk = 4'($urandom);
      model_step(spk, exp_s);
      run_step(spk, got, lat);
      checks += 2;
      if (got !== exp_s) begin errors++; $display("FAIL rand_spikes_it%0d: got %b want %b", it, got, exp_s); end
      if (lat !== LAT) begin errors++; $display("FAIL rand_latency_it%0d: got %0d want %0d", it, lat, LAT); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; spikes_in = '0; out_ready = 1'b0;
    w_we = 1'b0; w_addr_n = '0; w_addr_p = '0; w_data = '0; clear_state = 1'b0;
    do_reset();
    test_reset();
    test_fire();
    test_refractory();
    test_leak();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
